// File: rtl/tile_ram_arbiter.sv
// Tile RAM arbiter: scan-out reads get fixed slots on tile boundaries; game writes
// and the board-clear sequencer use the remaining cycles. Also emits the frame tick.
`timescale 1ns/1ps
module tile_ram_arbiter #(
   parameter int GAME_WIDTH  = 40,
   parameter int GAME_HEIGHT = 30,
   parameter int DATA_WIDTH  = 1,
   parameter int ADDR_WIDTH  = 11,
   parameter int TILE_SHIFT  = 4,
   parameter int ACTIVE_COLS = 640,
   parameter int ACTIVE_ROWS = 480,
   parameter int CLEAR_VALUE = 0
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_L,
   input  logic [9:0]            i_Col_Count,
   input  logic [9:0]            i_Row_Count,
   input  logic                  i_Wr_Req,
   input  logic [ADDR_WIDTH-1:0] i_Wr_Addr,
   input  logic [DATA_WIDTH-1:0] i_Wr_Data,
   output logic                  o_Wr_Ack,
   output logic                  o_Wr_Err,
   input  logic                  i_Clear_Req,
   output logic                  o_Clear_Busy,
   output logic                  o_Ram_En,
   output logic                  o_Ram_We,
   output logic [ADDR_WIDTH-1:0] o_Ram_Addr,
   output logic [DATA_WIDTH-1:0] o_Ram_Wdata,
   input  logic [DATA_WIDTH-1:0] i_Ram_Rdata,
   output logic [DATA_WIDTH-1:0] o_Pix_Data,
   output logic                  o_Pix_Valid,
   output logic                  o_Frame_Tick
);
   localparam int NUM_TILES = GAME_WIDTH * GAME_HEIGHT;
   localparam int STAGES    = 3;
   localparam logic [9:0]            COL_MAX = 10'(ACTIVE_COLS);
   localparam logic [9:0]            ROW_MAX = 10'(ACTIVE_ROWS);
   localparam logic [ADDR_WIDTH-1:0] GW      = ADDR_WIDTH'(GAME_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(NUM_TILES - 1);
   localparam logic [ADDR_WIDTH:0]   LIMIT   = (ADDR_WIDTH+1)'(NUM_TILES);
   localparam logic [DATA_WIDTH-1:0] CLR     = DATA_WIDTH'(CLEAR_VALUE);

   typedef enum logic {IDLE, CLEAR} state_t;

   typedef struct packed {
      logic                  en;
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } ram_req_t;

   state_t                state;
   ram_req_t              ram;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  active, disp, wr_bad;
   logic [ADDR_WIDTH-1:0] disp_addr;
   logic [STAGES-1:0]     vld_pipe;
   logic [STAGES-2:0]     ld_pipe;
   logic [DATA_WIDTH-1:0] pix;

   assign active    = (i_Col_Count < COL_MAX) && (i_Row_Count < ROW_MAX);
   assign disp      = active && (i_Col_Count[TILE_SHIFT-1:0] == '0);
   assign disp_addr = ADDR_WIDTH'(i_Row_Count >> TILE_SHIFT) * GW
                    + ADDR_WIDTH'(i_Col_Count >> TILE_SHIFT);
   assign wr_bad    = {1'b0, i_Wr_Addr} >= LIMIT;

   assign o_Ram_En    = ram.en;
   assign o_Ram_We    = ram.we;
   assign o_Ram_Addr  = ram.addr;
   assign o_Ram_Wdata = ram.wdata;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state        <= IDLE;
         clr_addr     <= '0;
         ram          <= '0;
         o_Wr_Ack     <= 1'b0;
         o_Wr_Err     <= 1'b0;
         o_Clear_Busy <= 1'b0;
         o_Frame_Tick <= 1'b0;
      end else begin
         ram          <= '0;
         o_Wr_Ack     <= 1'b0;
         o_Wr_Err     <= 1'b0;
         o_Frame_Tick <= (i_Row_Count == ROW_MAX) && (i_Col_Count == '0);
         case (state)
            IDLE: begin
               // busy drops one cycle after the final clear write issues
               o_Clear_Busy <= i_Clear_Req;
               if (i_Clear_Req) begin
                  state    <= CLEAR;
                  clr_addr <= '0;
               end else if (!disp && i_Wr_Req && !o_Wr_Ack) begin
                  o_Wr_Ack <= 1'b1;
                  if (wr_bad) o_Wr_Err <= 1'b1;
                  else        ram <= '{en: 1'b1, we: 1'b1, addr: i_Wr_Addr, wdata: i_Wr_Data};
               end
            end
            CLEAR: begin
               if (!disp) begin
                  ram <= '{en: 1'b1, we: 1'b1, addr: clr_addr, wdata: CLR};
                  if (clr_addr == LAST) state <= IDLE;
                  else                  clr_addr <= clr_addr + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
         // scan-out slot overrides whatever else was chosen this cycle
         if (disp) ram <= '{en: 1'b1, we: 1'b0, addr: disp_addr, wdata: '0};
      end
   end

   // Read issues at +1, RAM data at +2, pixel register loads at +3.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         vld_pipe <= '0;
         ld_pipe  <= '0;
         pix      <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-2:0], active};
         ld_pipe  <= {ld_pipe[STAGES-3:0], disp};
         pix      <= vld_pipe[STAGES-2] ? (ld_pipe[STAGES-2] ? i_Ram_Rdata : pix) : '0;
      end
   end

   assign o_Pix_Data  = pix;
   assign o_Pix_Valid = vld_pipe[STAGES-1];
endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Directed bench for tile_ram_arbiter with a behavioural single-port RAM model.
`timescale 1ns/1ps
module tb_tile_ram_arbiter;
   logic        i_Clk = 1'b0;
   logic        i_Rst_L;
   logic [9:0]  i_Col_Count, i_Row_Count;
   logic        i_Wr_Req;
   logic [10:0] i_Wr_Addr;
   logic [0:0]  i_Wr_Data;
   logic        o_Wr_Ack, o_Wr_Err;
   logic        i_Clear_Req;
   logic        o_Clear_Busy;
   logic        o_Ram_En, o_Ram_We;
   logic [10:0] o_Ram_Addr;
   logic [0:0]  o_Ram_Wdata;
   logic [0:0]  i_Ram_Rdata = '0;
   logic [0:0]  o_Pix_Data;
   logic        o_Pix_Valid, o_Frame_Tick;

   logic [0:0]  mem [0:2047];
   logic        run = 1'b0;
   int          n_chk = 0;
   int          n_err = 0;

   tile_ram_arbiter dut (
      .i_Clk(i_Clk), .i_Rst_L(i_Rst_L),
      .i_Col_Count(i_Col_Count), .i_Row_Count(i_Row_Count),
      .i_Wr_Req(i_Wr_Req), .i_Wr_Addr(i_Wr_Addr), .i_Wr_Data(i_Wr_Data),
      .o_Wr_Ack(o_Wr_Ack), .o_Wr_Err(o_Wr_Err),
      .i_Clear_Req(i_Clear_Req), .o_Clear_Busy(o_Clear_Busy),
      .o_Ram_En(o_Ram_En), .o_Ram_We(o_Ram_We), .o_Ram_Addr(o_Ram_Addr),
      .o_Ram_Wdata(o_Ram_Wdata), .i_Ram_Rdata(i_Ram_Rdata),
      .o_Pix_Data(o_Pix_Data), .o_Pix_Valid(o_Pix_Valid), .o_Frame_Tick(o_Frame_Tick)
   );

   always #5 i_Clk = ~i_Clk;

   always @(posedge i_Clk) begin
      if (o_Ram_En) begin
         if (o_Ram_We) mem[o_Ram_Addr] <= o_Ram_Wdata;
         else          i_Ram_Rdata     <= mem[o_Ram_Addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_Clk); #1;
      if (run) begin
         if (i_Col_Count == 10'd799) begin
            i_Col_Count = '0;
            i_Row_Count = (i_Row_Count == 10'd524) ? 10'd0 : i_Row_Count + 10'd1;
         end else i_Col_Count = i_Col_Count + 10'd1;
      end
   endtask

   task automatic set_pos(input int r, input int c);
      i_Row_Count = 10'(r);
      i_Col_Count = 10'(c);
   endtask

   task automatic chk_ram(input string tag, input logic en, input logic we,
                          input int addr, input logic [0:0] wd);
      chk(tag, {o_Ram_En, o_Ram_We, o_Ram_Addr, o_Ram_Wdata},
          {en, we, 11'(addr), wd});
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {o_Ram_En, o_Ram_We, o_Ram_Addr, o_Ram_Wdata, o_Wr_Ack, o_Wr_Err,
                o_Clear_Busy, o_Pix_Data, o_Pix_Valid, o_Frame_Tick}, 32'd0);
   endtask

   // Runs a tile starting at (r,c); expects pixel value exp for 16 clocks from +3.
   task automatic pix_run(input string tag, input int r, input int c, input logic [0:0] exp,
                          input logic tail_valid);
      int bad;
      bad = 0;
      set_pos(r, c);
      run = 1'b1;
      step();
      chk_ram({tag, "_rd"}, 1'b1, 1'b0, (r >> 4) * 40 + (c >> 4), 1'b0);
      step();
      for (int j = 3; j <= 18; j++) begin
         step();
         if (o_Pix_Data !== exp || o_Pix_Valid !== 1'b1) bad++;
      end
      chk({tag, "_hold"}, bad, 0);
      step();
      chk({tag, "_tail_valid"}, o_Pix_Valid, tail_valid);
      chk({tag, "_tail_data"}, o_Pix_Data, 1'b0);
      run = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int bad, bbad, ticks, tick_at;
      i_Rst_L = 1'b0; i_Wr_Req = 1'b0; i_Wr_Addr = '0; i_Wr_Data = '0; i_Clear_Req = 1'b0;
      set_pos(500, 10);
      step(); step();
      chk_zero("reset_state");
      i_Rst_L = 1'b1;
      step();
      chk_zero("idle_after_reset");

      // clear and write requested together in blanking
      i_Clear_Req = 1'b1; i_Wr_Req = 1'b1; i_Wr_Addr = 11'd7; i_Wr_Data = 1'b1;
      step();
      i_Clear_Req = 1'b0;
      chk("clr_busy_rise", {o_Clear_Busy, o_Ram_En, o_Wr_Ack}, 3'b100);
      bad = 0; bbad = 0;
      for (int i = 0; i < 1200; i++) begin
         step();
         if (!(o_Ram_En && o_Ram_We && o_Ram_Addr == 11'(i) && o_Ram_Wdata == 1'b0)) bad++;
         if (o_Clear_Busy !== 1'b1 || o_Wr_Ack !== 1'b0) bbad++;
      end
      chk("clr_seq", bad, 0);
      chk("clr_busy_ack", bbad, 0);
      step();
      chk("clr_busy_fall", o_Clear_Busy, 1'b0);
      chk("pend_ack", {o_Wr_Ack, o_Wr_Err}, 2'b10);
      chk_ram("pend_wr", 1'b1, 1'b1, 7, 1'b1);
      i_Wr_Req = 1'b0;
      step();
      chk("pend_ack_once", o_Wr_Ack, 1'b0);

      // held request: one ack, next write spaced 2 cycles
      i_Wr_Req = 1'b1; i_Wr_Addr = 11'd5; i_Wr_Data = 1'b1;
      step();
      chk_ram("wr5", 1'b1, 1'b1, 5, 1'b1);
      chk("wr5_ack", {o_Wr_Ack, o_Wr_Err}, 2'b10);
      i_Wr_Addr = 11'd83;
      step();
      chk("wr_gap", {o_Ram_En, o_Wr_Ack}, 2'b00);
      step();
      chk_ram("wr83", 1'b1, 1'b1, 83, 1'b1);
      i_Wr_Addr = 11'd119;
      step(); step();
      chk_ram("wr119", 1'b1, 1'b1, 119, 1'b1);
      i_Wr_Req = 1'b0;
      step();
      chk("wr_idle", {o_Ram_En, o_Wr_Ack}, 2'b00);

      // out-of-range address
      i_Wr_Req = 1'b1; i_Wr_Addr = 11'd1200;
      step();
      chk("oor", {o_Ram_En, o_Wr_Ack, o_Wr_Err}, 3'b011);
      i_Wr_Req = 1'b0;
      step();
      chk("oor_pulse", {o_Wr_Ack, o_Wr_Err}, 2'b00);

      // pixel pipeline
      set_pos(32, 48);
      run = 1'b1;
      step();
      chk_ram("pix_rd83", 1'b1, 1'b0, 83, 1'b0);
      step();
      chk("pix_early", {o_Pix_Data, o_Pix_Valid}, 2'b00);
      step();
      chk("pix_t3", {o_Pix_Data, o_Pix_Valid}, 2'b11);
      run = 1'b0;
      pix_run("tile83", 32, 48, 1'b1, 1'b1);
      pix_run("tile119", 32, 624, 1'b1, 1'b0);
      pix_run("tile5", 0, 80, 1'b1, 1'b1);
      pix_run("tile1", 0, 16, 1'b0, 1'b1);

      // write colliding with a display slot
      set_pos(0, 0);
      run = 1'b1;
      i_Wr_Req = 1'b1; i_Wr_Addr = 11'd9; i_Wr_Data = 1'b1;
      step();
      chk_ram("coll_rd0", 1'b1, 1'b0, 0, 1'b0);
      chk("coll_noack", o_Wr_Ack, 1'b0);
      step();
      chk_ram("coll_wr9", 1'b1, 1'b1, 9, 1'b1);
      chk("coll_ack", o_Wr_Ack, 1'b1);
      i_Wr_Req = 1'b0;
      run = 1'b0;

      // reset in the middle of a clear
      set_pos(500, 10);
      step();
      i_Clear_Req = 1'b1;
      step();
      i_Clear_Req = 1'b0;
      for (int i = 0; i < 601; i++) step();
      chk_ram("clr600", 1'b1, 1'b1, 600, 1'b0);
      i_Rst_L = 1'b0;
      #1;
      chk_zero("async_reset");
      #1;
      i_Rst_L = 1'b1;
      step();
      chk("post_rst_idle", {o_Ram_En, o_Clear_Busy}, 2'b00);

      set_pos(479, 790);
      run = 1'b1;
      ticks = 0; tick_at = -1;
      for (int j = 1; j <= 900; j++) begin
         step();
         if (o_Frame_Tick) begin
            ticks++;
            if (tick_at < 0) tick_at = j;
         end
      end
      chk("tick_count", ticks, 1);
      chk("tick_time", tick_at, 11);
      run = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
